pmem_line_responder: RTL
========================

# pmem_line_responder

Physical-memory-side responder for the cache's line-fill/write-back interface. It accepts one 128-bit line read or write at a time from the cache and holds it for a fixed, parameterised latency. It then completes the request against an internal line-addressed backing store and pulses `pmem_resp` for exactly one cycle. It is the synthesizable stand-in for physical memory that terminates the cache's `pmem_*` port in simulation and on FPGA.

## Interface
- `LATENCY`, default 4: cycles from the request being sampled to `pmem_resp`. Legal range 1..15.
- `LINE_BITS`, default 8: log2 of the number of lines in the backing store. 256 lines × 16 B = 4 KB.
- Ports:
  - `clk` in, 1: single clock. All state updates on the rising edge.
  - `reset` in, 1: synchronous, active-high.
  - `pmem_read` in, 1: line read request. Level; held until `pmem_resp`.
  - `pmem_write` in, 1: line write request. Level; held until `pmem_resp`.
  - `pmem_address` in, 16: byte address of the line. Bits [3:0] are ignored.
  - `pmem_wdata` in, 128: write line data, type `lc3b_memband`.
  - `pmem_resp` out, 1: one-cycle completion pulse.
  - `pmem_rdata` out, 128: read line data, type `lc3b_memband`. Registered.
  - `pmem_error` out, 1: sticky protocol-violation flag.

## Operation
- Line index = `pmem_address[LINE_BITS+3:4]`. Address bits above the index are ignored, so addresses alias modulo 2^(LINE_BITS+4).
- The backing store is `2^LINE_BITS` × 128 bits. It is not cleared by `reset`, and its contents are undefined until written.
- The FSM has three states: IDLE, BUSY, RESP.
- **IDLE:**
  - `pmem_read` or `pmem_write` high at an edge latches the op, index and `pmem_wdata`, and loads the counter with `LATENCY-1`.
  - If `LATENCY`=1, the next state is RESP; otherwise BUSY.
- **BUSY:**
  - The counter decrements each edge. When the counter is 1 at an edge, the next state is RESP.
  - Input changes during BUSY are ignored; the latched values are used.
- **RESP:**
  - `pmem_resp`=1 for this cycle only. The next state is always IDLE.
  - Read: `pmem_rdata` is loaded from the store at the edge entering RESP and is valid throughout the RESP cycle. It then holds that value until the next read response.
  - Write: the store line is written at the edge leaving RESP. `pmem_rdata` is unchanged.
- The requester must deassert its request in the cycle after `pmem_resp`. IDLE samples a new request immediately, so back-to-back write-back then fill costs no bubble.
- If `pmem_read` and `pmem_write` are both high when sampled in IDLE:
  - The request is treated as a write.
  - `pmem_error` is set to 1 and stays set until `reset`.
- A read of a line written by an earlier completed write returns the new data (the write has committed before IDLE).
- Counter width is 4 bits; there is no wrap within the legal `LATENCY` range.

## Timing
- Reset values:
  - state = IDLE
  - `pmem_resp`=0
  - `pmem_rdata`=0
  - `pmem_error`=0
  - counter = 0
- Latency: if the request is first high in cycle T, `pmem_resp` is high in cycle T+`LATENCY` only.
- Throughput: one request per `LATENCY`+1 cycles, measured first-sample to first-sample of back-to-back requests.
- Reset mid-operation (BUSY or RESP): the FSM returns to IDLE next cycle.
  - No `pmem_resp` is issued.
  - The pending write is discarded and the store is unchanged.
  - `pmem_rdata` is cleared to 0.
- `reset` takes priority over any request sampled in the same edge.

## Test plan
- **Reset:** hold `reset` 2 cycles with `pmem_read`=1. Required: `pmem_resp`=0, `pmem_rdata`=0 and `pmem_error`=0 throughout, and no response until 4 cycles after release.
- **Write then read** (`LATENCY`=4):
  - Write 0x0040 with data 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, first high in cycle 10. Required: `pmem_resp` high in cycle 14 only.
  - Read 0x0040 from cycle 15. Required: `pmem_resp` high in cycle 19 with `pmem_rdata` equal to the written value.
- **Aliasing/offset:**
  - Write 0x0050 = 128'hAAAA…A. Required: a read of 0x1050 returns 128'hAAAA…A.
  - Read 0x005E. Required: returns the same line.
- **Back-to-back:** write 0x0060 deasserted the cycle after `pmem_resp`, with a read of 0x0070 asserted that same cycle. Required: the read is accepted with no idle cycle, and `pmem_resp` arrives 4 cycles later.
- **Protocol violation:** `pmem_read`=`pmem_write`=1 at 0x0080 with data 128'h5555…5. Required: a write response after 4 cycles, `pmem_error`=1 from the sampling edge onward and held until `reset`, and a later read of 0x0080 returns 128'h5555…5.
- **Reset mid-write:**
  - Line 0x0090 holds 128'h1111…1.
  - Write 128'h2222…2 to it, then assert `reset` 2 cycles after the request. Required: no `pmem_resp` is issued.
  - Read 0x0090 after reset. Required: returns 128'h1111…1.

Source files
------------

// File: rtl/pmem_line_responder.sv
// pmem_line_responder: fixed-latency 128-bit line memory terminating the cache pmem port.
module pmem_line_responder #(
    parameter int LATENCY   = 4,
    parameter int LINE_BITS = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    output logic         pmem_resp,
    output logic [127:0] pmem_rdata,
    output logic         pmem_error
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t               state_q;
    logic [3:0]           cnt_q;
    logic                 wr_q, resp_q, error_q;
    logic [LINE_BITS-1:0] idx_q, idx_d;
    logic [127:0]         wdata_q, rdata_q;
    logic [127:0]         mem [2**LINE_BITS];
    logic                 unused_addr;
    assign idx_d       = pmem_address[LINE_BITS+3:4];
    assign unused_addr = ^{pmem_address[15:LINE_BITS+4], pmem_address[3:0]};
    assign pmem_resp   = resp_q;
    assign pmem_rdata  = rdata_q;
    assign pmem_error  = error_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
            error_q <= 1'b0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            resp_q <= 1'b0;
            case (state_q)
                IDLE: if (pmem_read || pmem_write) begin
                    wr_q    <= pmem_write;
                    idx_q   <= idx_d;
                    wdata_q <= pmem_wdata;
                    cnt_q   <= 4'(LATENCY - 1);
                    error_q <= error_q | (pmem_read & pmem_write);
                    // A single-cycle latency skips BUSY, so read the store with the live index.
                    if (LATENCY == 1) begin
                        state_q <= RESP;
                        resp_q  <= 1'b1;
                        if (!pmem_write) rdata_q <= mem[idx_d];
                    end else begin
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= RESP;
                        resp_q  <= 1'b1;
                        if (!wr_q) rdata_q <= mem[idx_q];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    // Writes commit on the edge leaving RESP; a reset on that edge discards them.
    always_ff @(posedge clk) begin
        if (!reset && state_q == RESP && wr_q) mem[idx_q] <= wdata_q;
    end
endmodule
